// File: rtl/viterbi_ctrl_pkg.sv
// Shared types and constants for the Viterbi link controller.
// Holds the FSM state encoding, code constraint length and counter widths.
package viterbi_ctrl_pkg;

    localparam int unsigned K        = 3;
    localparam int unsigned TAIL_LEN = K - 1;
    localparam int unsigned CNT_W    = 8;
    // Wide enough for FRAME_LEN + TAIL_LEN - 1 at FRAME_LEN = 256, and for N up to 7.
    localparam int unsigned T_W      = 9;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StFlush,
        StDrain,
        StDone
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/viterbi_err_sched.sv
// Transmit-cycle counter and periodic error-injection scheduler.
// A slot fires on every transmit cycle whose low N counter bits are all ones.
module viterbi_err_sched
    import viterbi_ctrl_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             tx_now_i,
    input  logic             tx_next_i,
    input  logic             err_en_i,
    input  logic [1:0]       err_mask_i,
    output logic [T_W-1:0]   t_o,
    output logic [1:0]       err_inj_o,
    output logic [CNT_W-1:0] inj_ct_o
);

    logic [T_W-1:0]   t_q, t_d;
    logic             err_en_q;
    logic [1:0]       mask_q;
    logic             slot_q, slot_d;
    logic [1:0]       inj_q;
    logic [CNT_W-1:0] inj_ct_q, inj_ct_d;

    always_comb begin
        t_d = t_q;
        if (clr_i) begin
            t_d = '0;
        end else if (tx_now_i) begin
            t_d = t_q + 1'b1;
        end
        // t_d is 0 on the accept edge, so stale err_en/mask never reach a slot.
        slot_d = tx_next_i && err_en_q && (&t_d[N-1:0]);

        inj_ct_d = inj_ct_q;
        if (clr_i) begin
            inj_ct_d = '0;
        end else if (slot_q) begin
            inj_ct_d = sat_inc(inj_ct_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q      <= '0;
            err_en_q <= 1'b0;
            mask_q   <= '0;
            slot_q   <= 1'b0;
            inj_q    <= '0;
            inj_ct_q <= '0;
        end else begin
            t_q      <= t_d;
            slot_q   <= slot_d;
            inj_q    <= slot_d ? mask_q : 2'b00;
            inj_ct_q <= inj_ct_d;
            if (clr_i) begin
                err_en_q <= err_en_i;
                mask_q   <= err_mask_i;
            end
        end
    end

    assign t_o       = t_q;
    assign err_inj_o = inj_q;
    assign inj_ct_o  = inj_ct_q;

endmodule

// File: rtl/viterbi_link_ctrl.sv
// Frame sequencer around a convolutional encoder / Viterbi decoder link.
// Streams a payload plus tail, injects scheduled channel errors and counts decoded-bit errors.
module viterbi_link_ctrl
    import viterbi_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned DEC_LAT   = 8,
    parameter int unsigned N         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [FRAME_LEN-1:0] payload_i,
    input  logic                 err_en_i,
    input  logic [1:0]           err_mask_i,
    output logic                 enc_enable_o,
    output logic                 enc_data_o,
    output logic [1:0]           err_inj_o,
    input  logic                 dec_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     bit_err_ct_o,
    output logic [CNT_W-1:0]     inj_ct_o
);

    localparam logic [T_W-1:0] LastSend  = T_W'(FRAME_LEN - 1);
    localparam logic [T_W-1:0] LastFlush = T_W'(FRAME_LEN + TAIL_LEN - 1);

    state_e               state_q, state_d;
    logic [FRAME_LEN-1:0] sh_q, sh_d;
    logic [T_W-1:0]       t;
    logic                 accept, tx_now;
    logic                 enc_en_q, enc_en_d;
    logic                 enc_data_q, enc_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DEC_LAT-1:0]   vld_q, vld_d, exp_q, exp_d, lst_q, lst_d;
    logic                 cap_valid, cap_last, cap_err;
    logic                 last_seen_q, last_seen_d;
    logic [CNT_W-1:0]     bit_err_q, bit_err_d;

    assign accept    = (state_q == StIdle) && start_i;
    assign tx_now    = (state_q == StSend) || (state_q == StFlush);
    assign cap_valid = vld_q[DEC_LAT-1];
    assign cap_last  = cap_valid && lst_q[DEC_LAT-1];
    assign cap_err   = cap_valid && (dec_data_i != exp_q[DEC_LAT-1]);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StSend;
            StSend:  if (t == LastSend) state_d = StFlush;
            StFlush: if (t == LastFlush) state_d = StDrain;
            // last_seen_q covers DEC_LAT short enough for the last capture to land in FLUSH.
            StDrain: if (cap_last || last_seen_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        sh_d = sh_q;
        if (accept) begin
            sh_d = payload_i;
        end else if (state_q == StSend) begin
            sh_d = sh_q >> 1;
        end

        enc_en_d   = (state_d == StSend) || (state_d == StFlush);
        enc_data_d = 1'b0;
        if (state_d == StSend) begin
            enc_data_d = accept ? payload_i[0] : sh_q[1];
        end
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);

        // Delay line tagging each sent bit with its reference value and last-bit flag.
        vld_d    = '0;
        exp_d    = '0;
        lst_d    = '0;
        vld_d[0] = (state_q == StSend);
        exp_d[0] = enc_data_q;
        lst_d[0] = (state_q == StSend) && (t == LastSend);
        for (int i = 1; i < int'(DEC_LAT); i++) begin
            vld_d[i] = vld_q[i-1];
            exp_d[i] = exp_q[i-1];
            lst_d[i] = lst_q[i-1];
        end

        last_seen_d = last_seen_q;
        bit_err_d   = bit_err_q;
        if (accept) begin
            last_seen_d = 1'b0;
            bit_err_d   = '0;
        end else begin
            if (cap_last) last_seen_d = 1'b1;
            if (cap_err)  bit_err_d = sat_inc(bit_err_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            enc_en_q    <= 1'b0;
            enc_data_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_q       <= '0;
            exp_q       <= '0;
            lst_q       <= '0;
            last_seen_q <= 1'b0;
            bit_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            enc_en_q    <= enc_en_d;
            enc_data_q  <= enc_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vld_q       <= vld_d;
            exp_q       <= exp_d;
            lst_q       <= lst_d;
            last_seen_q <= last_seen_d;
            bit_err_q   <= bit_err_d;
        end
    end

    viterbi_err_sched #(
        .N (N)
    ) u_err_sched (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .tx_now_i   (tx_now),
        .tx_next_i  (enc_en_d),
        .err_en_i   (err_en_i),
        .err_mask_i (err_mask_i),
        .t_o        (t),
        .err_inj_o  (err_inj_o),
        .inj_ct_o   (inj_ct_o)
    );

    assign enc_enable_o = enc_en_q;
    assign enc_data_o   = enc_data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign bit_err_ct_o = bit_err_q;

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Directed bench for viterbi_link_ctrl with an ideal delay-line decoder model.
// A second instance at FRAME_LEN=256 exercises bit-error counter saturation.
module tb_viterbi_link_ctrl;

    localparam int FL = 64;
    localparam int DL = 8;
    localparam int NN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, err_en, enc_en, enc_data, dec, busy, done;
    logic [63:0] payload;
    logic [1:0]  mask, inj;
    logic [7:0]  bec, ic;

    logic         start_b, enc_en_b, enc_data_b, dec_b, busy_b, done_b;
    logic [255:0] payload_b;
    logic [1:0]   inj_b;
    logic [7:0]   bec_b, ic_b;

    viterbi_link_ctrl #(.FRAME_LEN(FL), .DEC_LAT(DL), .N(NN)) dut (
        .clk(clk), .rst(rst), .start_i(start), .payload_i(payload), .err_en_i(err_en),
        .err_mask_i(mask), .enc_enable_o(enc_en), .enc_data_o(enc_data), .err_inj_o(inj),
        .dec_data_i(dec), .busy_o(busy), .done_o(done), .bit_err_ct_o(bec), .inj_ct_o(ic)
    );

    viterbi_link_ctrl #(.FRAME_LEN(256), .DEC_LAT(DL), .N(NN)) dut_big (
        .clk(clk), .rst(rst), .start_i(start_b), .payload_i(payload_b), .err_en_i(1'b0),
        .err_mask_i(2'b00), .enc_enable_o(enc_en_b), .enc_data_o(enc_data_b),
        .err_inj_o(inj_b), .dec_data_i(dec_b), .busy_o(busy_b), .done_o(done_b),
        .bit_err_ct_o(bec_b), .inj_ct_o(ic_b)
    );

    // Ideal decoder: encoder input delayed DL cycles, with selected payload bits inverted.
    logic [63:0]   inv_mask = '0;
    logic [7:0]    k_tb = '0;
    logic [DL-1:0] dly = '0;
    logic [DL-1:0] dly_b = '0;
    always @(posedge clk) begin
        if (!busy) k_tb <= '0;
        else if (enc_en) k_tb <= k_tb + 8'd1;
        dly   <= {dly[DL-2:0], enc_data ^ (enc_en && (k_tb < 8'd64) && inv_mask[k_tb[5:0]])};
        dly_b <= {dly_b[DL-2:0], ~enc_data_b};
    end
    assign dec   = dly[DL-1];
    assign dec_b = dly_b[DL-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int r_en, r_busy, r_done, r_dcyc, r_inj, r_bad_data, r_bad_inj, r_end;

    // Runs one frame; cycle 1 is the first SEND cycle, loop stops on the first idle cycle.
    task automatic run_frame(input logic [63:0] pl, input logic een, input logic [1:0] m,
                             input logic hold);
        logic       exp_d;
        logic [1:0] exp_i;
        int         k;
        payload = pl; err_en = een; mask = m; start = 1'b1;
        r_en = 0; r_busy = 0; r_done = 0; r_dcyc = 0; r_inj = 0;
        r_bad_data = 0; r_bad_inj = 0; r_end = 0;
        for (int c = 1; c <= 300; c++) begin
            step();
            if (!hold) start = 1'b0;
            exp_d = 1'b0;
            exp_i = 2'b00;
            if (enc_en) begin
                k = r_en;
                r_en++;
                if (k < FL) exp_d = pl[k];
                if (een && ((k % (1 << NN)) == (1 << NN) - 1)) exp_i = m;
            end
            if (enc_data !== exp_d) r_bad_data++;
            if (inj !== exp_i) r_bad_inj++;
            if (inj != 2'b00) r_inj++;
            if (busy) r_busy++;
            if (done) begin
                r_done++;
                r_dcyc = c;
            end
            if (!busy) begin
                r_end = c;
                break;
            end
        end
    endtask

    int dseen, dcyc;

    initial begin
        rst = 1'b1; start = 1'b0; err_en = 1'b0; payload = '0; mask = 2'b00;
        start_b = 1'b0; payload_b = {8{32'hDEAD_BEEF}};
        repeat (3) step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_enc_en", enc_en, 0);
        check_eq("rst_enc_data", enc_data, 0);
        check_eq("rst_inj", inj, 0);
        check_eq("rst_bit_err", bec, 0);
        check_eq("rst_inj_ct", ic, 0);
        rst = 1'b0;

        // Clean frame, no injection.
        run_frame(64'hA5A5_0F0F_1234_5678, 1'b0, 2'b00, 1'b0);
        check_eq("a_enable_cycles", r_en, 66);
        check_eq("a_bad_data", r_bad_data, 0);
        check_eq("a_bad_inj", r_bad_inj, 0);
        check_eq("a_done_cycle", r_dcyc, 73);
        check_eq("a_done_pulses", r_done, 1);
        check_eq("a_busy_cycles", r_busy, 73);
        check_eq("a_idle_cycle", r_end, 74);
        check_eq("a_bit_err", bec, 0);
        check_eq("a_inj_ct", ic, 0);

        // Injection every 16 transmit cycles: t = 15, 31, 47, 63.
        run_frame(64'hFFFF_0000_5555_AAAA, 1'b1, 2'b01, 1'b0);
        check_eq("b_inj_cycles", r_inj, 4);
        check_eq("b_bad_inj", r_bad_inj, 0);
        check_eq("b_inj_ct", ic, 4);
        check_eq("b_bit_err", bec, 0);
        check_eq("b_done_pulses", r_done, 1);
        repeat (5) step();
        check_eq("b_inj_ct_hold", ic, 4);

        // Decoder flips bits 3 and 40.
        inv_mask = 64'h0000_0100_0000_0008;
        run_frame(64'h0123_4567_89AB_CDEF, 1'b0, 2'b00, 1'b0);
        check_eq("c_bit_err", bec, 2);
        check_eq("c_done_pulses", r_done, 1);
        inv_mask = '0;

        // start held high: exactly one frame, one idle cycle, then a new frame.
        run_frame(64'hCAFE_F00D_0BAD_BEEF, 1'b0, 2'b00, 1'b1);
        check_eq("d_done_pulses", r_done, 1);
        check_eq("d_busy_cycles", r_busy, 73);
        check_eq("d_idle_cycle", r_end, 74);
        step();
        check_eq("d_restart_busy", busy, 1);
        start = 1'b0;
        dseen = 0;
        for (int c = 0; c < 200; c++) begin
            if (done) dseen++;
            if (!busy) break;
            step();
        end
        check_eq("d_second_done", dseen, 1);
        check_eq("d_second_idle", busy, 0);

        // Reset at SEND k=20 with an error and an injection already counted.
        inv_mask = 64'h0000_0000_0000_0008;
        payload = 64'h1111_2222_3333_4444; err_en = 1'b1; mask = 2'b10; start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        check_eq("e_pre_enable", enc_en, 1);
        check_eq("e_pre_bit_err", bec, 1);
        check_eq("e_pre_inj_ct", ic, 1);
        rst = 1'b1;
        step();
        check_eq("e_busy", busy, 0);
        check_eq("e_enable", enc_en, 0);
        check_eq("e_bit_err", bec, 0);
        check_eq("e_inj_ct", ic, 0);
        rst = 1'b0;
        inv_mask = '0;
        dseen = 0;
        for (int c = 0; c < 80; c++) begin
            if (done || busy) dseen++;
            step();
        end
        check_eq("e_no_done", dseen, 0);
        check_eq("e_bit_err_quiet", bec, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_frame(64'h8000_0000_0000_0001, 1'b1, 2'b11, 1'b0);
        check_eq("e_new_done_cycle", r_dcyc, 73);
        check_eq("e_new_enable", r_en, 66);
        check_eq("e_new_bad_data", r_bad_data, 0);
        check_eq("e_new_bad_inj", r_bad_inj, 0);
        check_eq("e_new_inj_ct", ic, 4);

        // 256-bit frame with every decoded bit inverted saturates the error counter.
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        dseen = 0; dcyc = 0;
        for (int c = 1; c <= 700; c++) begin
            if (done_b) begin
                dseen++;
                dcyc = c;
            end
            if (!busy_b) break;
            step();
        end
        check_eq("f_done_pulses", dseen, 1);
        check_eq("f_done_cycle", dcyc, 265);
        check_eq("f_bit_err_sat", bec_b, 255);
        check_eq("f_inj_ct", ic_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_link_ctrl.md
VITERBI_LINK_CTRL -- requirements
Module: viterbi_link_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 64, payload bits per frame (legal 2..256).
REQ-002 Parameter DEC_LAT, default 8, cycles from an encoder input bit to its decoded bit on dec_data_i (legal >=1).
REQ-003 Parameter N, default 4, error-injection period exponent; an injection slot occurs every 2**N transmit cycles (legal 1..7).
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port start_i  input  1  frame request, sampled only in IDLE.
REQ-007 Port payload_i  input  FRAME_LEN  frame data, bit 0 transmitted first, latched on accepted start.
REQ-008 Port err_en_i  input  1  enables scheduled error injection for the frame, latched on accepted start.
REQ-009 Port err_mask_i  input  2  XOR pattern for encoder symbol, latched on accepted start.
REQ-010 Port enc_enable_o  output  1  encoder enable.
REQ-011 Port enc_data_o  output  1  encoder input bit.
REQ-012 Port err_inj_o  output  2  mask XORed by the channel onto the encoder output symbol.
REQ-013 Port dec_data_i  input  1  decoder output bit.
REQ-014 Port busy_o  output  1  high in every state except IDLE.
REQ-015 Port done_o  output  1  one-cycle completion pulse.
REQ-016 Port bit_err_ct_o  output  8  decoded-bit mismatches in last frame, saturating at 255.
REQ-017 Port inj_ct_o  output  8  injection slots applied in last frame, saturating at 255.

Function
REQ-018 States SHALL be IDLE, SEND, FLUSH, DRAIN, DONE.
REQ-019 IDLE: start_i=1 latches payload_i/err_en_i/err_mask_i, clears both counters, enters SEND next cycle; start_i in any other state SHALL be ignored.
REQ-020 SEND: FRAME_LEN cycles, enc_enable_o=1, enc_data_o=payload[k] on the k-th SEND cycle (k from 0).
REQ-021 FLUSH: TAIL_LEN (=2) cycles, enc_enable_o=1, enc_data_o=0; then DRAIN.
REQ-022 Transmit cycle counter t SHALL be 0 on first SEND cycle and increment through SEND and FLUSH.
REQ-023 err_inj_o SHALL equal latched mask when err_en latched high, state in {SEND,FLUSH}, and t[N-1:0] all ones; else 2'b00; each such cycle increments inj_ct (saturating).
REQ-024 Capture: decoded bit k SHALL be sampled from dec_data_i exactly DEC_LAT cycles after the k-th SEND cycle, compared to payload[k], mismatch increments bit_err_ct (saturating); capture runs independent of state.
REQ-025 DRAIN SHALL exit to DONE the cycle after capture of bit FRAME_LEN-1.
REQ-026 DONE: done_o=1 for exactly one cycle, then IDLE; counters hold until next accepted start.
REQ-027 enc_enable_o, enc_data_o, err_inj_o SHALL be 0 in IDLE, DRAIN, DONE.
REQ-028 All outputs SHALL be registered; counter arithmetic 8-bit, no wrap.

Reset
REQ-029 rst=1 at any clock edge, including mid-frame, SHALL force IDLE, all outputs 0, both counters 0, capture pipeline cleared; first start accepted the cycle after rst falls.

Structure
REQ-030 Package viterbi_ctrl_pkg SHALL hold the state enum, K=3, TAIL_LEN=K-1, counter width 8.
REQ-031 Injection-slot logic (t counter, slot detect, inj_ct) SHALL be sub-module viterbi_err_sched.

Verification
REQ-032 err_en=0, payload=64'hA5A5_0F0F_1234_5678, ideal decoder model -> 66 enable cycles, done at cycle 64+DEC_LAT+1 after SEND entry, bit_err_ct=0, inj_ct=0.
REQ-033 err_en=1, mask=2'b01, N=4 -> err_inj_o=01 at t=15,31,47,63, inj_ct=4, no other nonzero err_inj_o.
REQ-034 Decoder model inverting decoded bits 3 and 40 -> bit_err_ct=2; all bits inverted, FRAME_LEN=256 -> bit_err_ct=255 (saturated).
REQ-035 start_i held high through frame -> one frame only, busy_o high 64+2+DRAIN+1 cycles, next frame starts only after return to IDLE.
REQ-036 rst asserted at SEND k=20 -> next cycle IDLE, enc_enable_o=0, counters 0, no done_o; new start completes normally.
